// File: rtl/apb_master_pkg.sv
// Shared types and defaults for the APB master and its wait-state timer.
package apb_master_pkg;

    localparam int unsigned DEF_ADDR_W  = 12;
    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    // Wait counter width; a disabled timeout still gets a 1-bit counter so
    // no zero-width vector is ever declared.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/apb_master_if.sv
// Command, response and APB-side signals of the APB master, bundled with
// the master (DUT) view and the slave (environment) view.
interface apb_master_if
    import apb_master_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic              tim_psel;
    logic              tim_penable;
    logic              tim_pwrite;
    logic [ADDR_W-1:0] tim_paddr;
    logic [DATA_W-1:0] tim_wdata;
    logic [DATA_W-1:0] tim_rdata;
    logic              tim_pready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
               tim_rdata, tim_pready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
               tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_wdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
               tim_rdata, tim_pready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
               tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_wdata
    );

endinterface

// File: rtl/apb_wait_timer.sv
// Clearable, saturating ACCESS wait-state counter. hit flags the last
// permitted wait cycle (count == TIMEOUT-1); it is held low when TIMEOUT=0.
module apb_wait_timer
    import apb_master_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic hit
);

    localparam int unsigned CNT_W = cnt_width(TIMEOUT);
    localparam bit          TO_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    // Count wait cycles, clearing on request and stopping at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign hit = TO_EN && (cnt == LIMIT);

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB master: valid/ready command in, APB SETUP/ACCESS
// transfer on tim_*, read data and timeout status out on a response channel.
// Every output is a register loaded from the value the next state implies.
module apb_master
    import apb_master_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    apb_master_if.master bus
);

    apb_state_e state;
    apb_state_e state_nxt;

    logic              accept;
    logic              wait_clr;
    logic              wait_inc;
    logic              wait_hit;

    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q,   rsp_err_d;
    logic              psel_q,      psel_d;
    logic              penable_q,   penable_d;
    logic              pwrite_q,    pwrite_d;
    logic [ADDR_W-1:0] paddr_q,     paddr_d;
    logic [DATA_W-1:0] wdata_q,     wdata_d;

    assign accept   = (state == ST_IDLE) && cmd_ready_q && bus.cmd_valid;
    assign wait_clr = (state == ST_SETUP);
    assign wait_inc = (state == ST_ACCESS) && !bus.tim_pready;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .clr   (wait_clr),
        .inc   (wait_inc),
        .hit   (wait_hit)
    );

    // State and output registers; everything returns to zero / IDLE on reset.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            wdata_q     <= '0;
        end else begin
            state       <= state_nxt;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            wdata_q     <= wdata_d;
        end
    end

    // Transfer sequencing: accept, one SETUP cycle, ACCESS until ready or
    // timeout, then hold the response until it is taken.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (accept) state_nxt = ST_SETUP;
            ST_SETUP:  state_nxt = ST_ACCESS;
            ST_ACCESS: if (bus.tim_pready || wait_hit) state_nxt = ST_RESP;
            ST_RESP:   if (bus.rsp_ready) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Next register values. Handshake and bus-phase flags follow the next
    // state so they line up with it; pready beats a same-cycle timeout.
    always_comb begin
        cmd_ready_d = (state_nxt == ST_IDLE);
        rsp_valid_d = (state_nxt == ST_RESP);
        psel_d      = (state_nxt == ST_SETUP) || (state_nxt == ST_ACCESS);
        penable_d   = (state_nxt == ST_ACCESS);
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        if (accept) begin
            pwrite_d = bus.cmd_write;
            paddr_d  = bus.cmd_addr;
            wdata_d  = bus.cmd_wdata;
        end

        if (state == ST_ACCESS) begin
            if (bus.tim_pready) begin
                rsp_rdata_d = pwrite_q ? '0 : bus.tim_rdata;
                rsp_err_d   = 1'b0;
            end else if (wait_hit) begin
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b1;
            end
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.tim_psel    = psel_q;
    assign bus.tim_penable = penable_q;
    assign bus.tim_pwrite  = pwrite_q;
    assign bus.tim_paddr   = paddr_q;
    assign bus.tim_wdata   = wdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed commands, a wait-state APB slave model,
// and a response scoreboard checked by an independent monitor.
module tb_apb_master;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Cycle index: value seen at a negedge identifies the current cycle.
    always @(posedge clk) cyc <= cyc + 1;

    apb_master_if #(.ADDR_W(12), .DATA_W(32)) bus  ();
    apb_master_if #(.ADDR_W(12), .DATA_W(32)) bus0 ();

    apb_master #(.ADDR_W(12), .DATA_W(32), .TIMEOUT(4)) u_dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus)
    );

    apb_master #(.ADDR_W(12), .DATA_W(32), .TIMEOUT(0)) u_dut0 (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus0)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          at;
    } exp_t;

    exp_t sb[$];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic void bound_expired(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired, got no event, required one (cycle %0d)", name, cyc);
    endfunction

    // APB slave model: pready after slv_wait ACCESS cycles, or always when forced.
    int          slv_wait  = 0;
    int          slv_cnt   = 0;
    bit          slv_force = 1'b0;
    logic [31:0] slv_rdata = '0;

    always @(negedge clk) begin
        bus.tim_rdata = slv_rdata;
        if (bus.tim_psel && bus.tim_penable) begin
            if (slv_force || slv_cnt >= slv_wait) begin
                bus.tim_pready = 1'b1;
            end else begin
                bus.tim_pready = 1'b0;
                slv_cnt++;
            end
        end else begin
            bus.tim_pready = slv_force;
            slv_cnt = 0;
        end
    end

    // Response monitor: on each new response pop the oldest expectation.
    logic prev_valid = 1'b0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (bus.rsp_valid && !prev_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rsp_valid=1, required no response (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_rdata", bus.rsp_rdata, mon_e.rdata);
                check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, mon_e.err});
                check("rsp_cycle", cyc, mon_e.at);
            end
        end
        prev_valid = bus.rsp_valid;
    end

    // Present a command; k returns the cycle whose closing edge accepts it.
    task automatic issue(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input int lat,
                         input bit track, output int k);
        exp_t e;
        int   b;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        b = 0;
        while (!bus.cmd_ready && b < 50) begin
            @(negedge clk);
            b++;
        end
        k = cyc;
        if (!bus.cmd_ready) begin
            bound_expired("cmd_accept");
            bus.cmd_valid = 1'b0;
        end else begin
            if (track) begin
                e.rdata = exp_rdata;
                e.err   = exp_err;
                e.at    = cyc + lat;
                sb.push_back(e);
            end
            @(posedge clk);
            #1;
            bus.cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int b = 0;
        while ((sb.size() != 0 || bus.rsp_valid) && b < 100) begin
            @(negedge clk);
            b++;
        end
        if (b >= 100) bound_expired("wait_idle");
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_cmd_ready"},   {31'd0, bus.cmd_ready},   32'd0);
        check({tag, "_rsp_valid"},   {31'd0, bus.rsp_valid},   32'd0);
        check({tag, "_rsp_rdata"},   bus.rsp_rdata,            32'd0);
        check({tag, "_rsp_err"},     {31'd0, bus.rsp_err},     32'd0);
        check({tag, "_psel"},        {31'd0, bus.tim_psel},    32'd0);
        check({tag, "_penable"},     {31'd0, bus.tim_penable}, 32'd0);
        check({tag, "_pwrite"},      {31'd0, bus.tim_pwrite},  32'd0);
        check({tag, "_paddr"},       {20'd0, bus.tim_paddr},   32'd0);
        check({tag, "_wdata"},       bus.tim_wdata,            32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, required completion (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, k2, r, b, pen_cnt;
        bit [5:0] pen_exp;
        bit [5:0] sel_exp;

        bus.cmd_valid  = 1'b0;
        bus.cmd_write  = 1'b0;
        bus.cmd_addr   = '0;
        bus.cmd_wdata  = '0;
        bus.rsp_ready  = 1'b1;
        bus0.cmd_valid = 1'b0;
        bus0.cmd_write = 1'b0;
        bus0.cmd_addr  = '0;
        bus0.cmd_wdata = '0;
        bus0.rsp_ready = 1'b1;
        bus0.tim_pready = 1'b0;
        bus0.tim_rdata  = '0;

        // Reset values, then cmd_ready one cycle after release.
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        check("cmd_ready_at_release", {31'd0, bus.cmd_ready}, 32'd0);
        @(negedge clk);
        check("cmd_ready_after_release", {31'd0, bus.cmd_ready}, 32'd1);

        // Zero-wait write.
        slv_wait  = 0;
        slv_rdata = 32'h1111_2222;
        issue(1'b1, 12'h004, 32'hDEAD_BEEF, 32'h0, 1'b0, 3, 1'b1, k);
        @(negedge clk);
        check("wr_setup_psel",    {31'd0, bus.tim_psel},    32'd1);
        check("wr_setup_penable", {31'd0, bus.tim_penable}, 32'd0);
        check("wr_setup_pwrite",  {31'd0, bus.tim_pwrite},  32'd1);
        check("wr_setup_paddr",   {20'd0, bus.tim_paddr},   32'h004);
        check("wr_setup_wdata",   bus.tim_wdata,            32'hDEAD_BEEF);
        @(negedge clk);
        check("wr_access_psel",    {31'd0, bus.tim_psel},    32'd1);
        check("wr_access_penable", {31'd0, bus.tim_penable}, 32'd1);
        check("wr_access_paddr",   {20'd0, bus.tim_paddr},   32'h004);
        check("wr_access_wdata",   bus.tim_wdata,            32'hDEAD_BEEF);
        @(negedge clk);
        check("wr_done_psel",    {31'd0, bus.tim_psel},    32'd0);
        check("wr_done_penable", {31'd0, bus.tim_penable}, 32'd0);
        check("wr_done_paddr_kept", {20'd0, bus.tim_paddr}, 32'h004);
        wait_idle();

        // Read with 3 wait states: pready arrives as the counter hits TIMEOUT-1.
        slv_wait  = 3;
        slv_rdata = 32'h1234_5678;
        issue(1'b0, 12'h010, 32'h0, 32'h1234_5678, 1'b0, 6, 1'b1, k);
        wait_idle();

        // Read with 2 wait states.
        slv_wait  = 2;
        slv_rdata = 32'h0000_00FF;
        issue(1'b0, 12'h014, 32'h0, 32'h0000_00FF, 1'b0, 5, 1'b1, k);
        wait_idle();

        // Timeout: penable for exactly 4 ACCESS cycles, error response at T+6.
        slv_wait  = 1000;
        slv_rdata = 32'h5555_AAAA;
        pen_exp   = 6'b011110;
        sel_exp   = 6'b011111;
        issue(1'b0, 12'h018, 32'h0, 32'h0, 1'b1, 6, 1'b1, k);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("timeout_penable", {31'd0, bus.tim_penable}, {31'd0, pen_exp[i]});
            check("timeout_psel",    {31'd0, bus.tim_psel},    {31'd0, sel_exp[i]});
        end
        wait_idle();

        // pready held high outside ACCESS must not shorten the transfer.
        slv_wait  = 0;
        slv_force = 1'b1;
        slv_rdata = 32'h0F0F_0F0F;
        issue(1'b0, 12'h01C, 32'h0, 32'h0F0F_0F0F, 1'b0, 3, 1'b1, k);
        wait_idle();
        slv_force = 1'b0;

        // Back-to-back zero-wait writes with rsp_ready high: 4-cycle spacing.
        issue(1'b1, 12'h100, 32'hAAAA_0001, 32'h0, 1'b0, 3, 1'b1, k);
        issue(1'b1, 12'h104, 32'hAAAA_0002, 32'h0, 1'b0, 3, 1'b1, k2);
        check("b2b_spacing", k2 - k, 32'd4);
        wait_idle();

        // Response backpressure with the next command already waiting.
        bus.rsp_ready = 1'b0;
        slv_rdata     = 32'hA5A5_0F0F;
        issue(1'b0, 12'h020, 32'h0, 32'hA5A5_0F0F, 1'b0, 3, 1'b1, k);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 12'h030;
        bus.cmd_wdata = 32'h0102_0304;
        b = 0;
        while (!bus.rsp_valid && b < 20) begin
            @(negedge clk);
            b++;
        end
        if (!bus.rsp_valid) bound_expired("bp_rsp_valid");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rsp_valid",  {31'd0, bus.rsp_valid}, 32'd1);
            check("bp_rsp_rdata",  bus.rsp_rdata,          32'hA5A5_0F0F);
            check("bp_cmd_ready",  {31'd0, bus.cmd_ready}, 32'd0);
            check("bp_psel",       {31'd0, bus.tim_psel},  32'd0);
        end
        r = cyc;
        bus.rsp_ready = 1'b1;
        slv_rdata     = 32'h0;
        issue(1'b1, 12'h030, 32'h0102_0304, 32'h0, 1'b0, 3, 1'b1, k2);
        check("bp_next_accept", k2, r + 1);
        wait_idle();

        // Reset in the middle of ACCESS: outputs clear at once, no response.
        slv_wait = 1000;
        issue(1'b0, 12'h024, 32'h0, 32'h0, 1'b0, 0, 1'b0, k);
        @(negedge clk);
        @(negedge clk);
        check("mid_access_penable", {31'd0, bus.tim_penable}, 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("mid_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        slv_wait  = 1;
        slv_rdata = 32'h0BAD_F00D;
        issue(1'b0, 12'h040, 32'h0, 32'h0BAD_F00D, 1'b0, 4, 1'b1, k);
        wait_idle();

        // TIMEOUT=0 instance: a stalled slave is waited on indefinitely.
        @(negedge clk);
        bus0.cmd_valid = 1'b1;
        bus0.cmd_write = 1'b0;
        bus0.cmd_addr  = 12'h008;
        b = 0;
        while (!bus0.cmd_ready && b < 20) begin
            @(negedge clk);
            b++;
        end
        if (!bus0.cmd_ready) bound_expired("t0_accept");
        @(posedge clk);
        #1;
        bus0.cmd_valid = 1'b0;
        @(negedge clk);
        pen_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus0.tim_penable && !bus0.rsp_valid) pen_cnt++;
        end
        check("t0_access_cycles", pen_cnt, 32'd300);
        bus0.tim_pready = 1'b1;
        bus0.tim_rdata  = 32'hCAFE_0001;
        @(negedge clk);
        bus0.tim_pready = 1'b0;
        check("t0_rsp_valid", {31'd0, bus0.rsp_valid}, 32'd1);
        check("t0_rsp_rdata", bus0.rsp_rdata,          32'hCAFE_0001);
        check("t0_rsp_err",   {31'd0, bus0.rsp_err},   32'd0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
